// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Upstream ready is registered; flush empties the stage; saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_next;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_next;
  logic              in_ready_q;
  logic              acc;
  logic              con;
  logic              stall;

  assign out_valid = (state != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready_q;
  assign con       = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  // Registers are cleared whenever the stage drains, so out_data is 0 while empty.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush) begin
      state_next = EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (acc && con) begin
            main_next = in_data;
          end else if (acc) begin
            state_next = FULL;
            skid_next  = in_data;
          end else if (con) begin
            state_next = EMPTY;
            main_next  = '0;
          end
        end
        FULL: begin
          if (con) begin
            state_next = ONE;
            main_next  = skid_q;
            skid_next  = '0;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      main_q     <= main_next;
      skid_q     <= skid_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor of the fixed IF/ID latch. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake with a two-entry skid buffer, so the upstream ready is registered rather than combinational. A synchronous flush inserts a bubble by emptying the stage. Saturating counters record stall and flush activity. It is used for every stage boundary of the datapath, including IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- DATA_W, 64: payload width in bits. For IF/ID this is {pcplus4, inst}.
- CNT_W, 16: width of each performance counter.

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat; registered
- in_data  in  DATA_W  upstream payload
- flush  in  1  synchronous bubble or squash request
- out_valid  out  1  beat held for the downstream stage
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  payload to the downstream stage; 0 whenever out_valid=0
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  saturating count of cycles with flush=1

## Operation
- Storage:
  - main register drives out_data.
  - skid register holds one overflow beat.
  - state ∈ {EMPTY, ONE, FULL}.
- Handshake terms:
  - acc = in_valid & in_ready.
  - con = out_valid & out_ready.
- Output decode:
  - out_valid = (state≠EMPTY).
  - in_ready = (state≠FULL), from a registered flag.
- Transitions when flush=0:
  - EMPTY: acc → ONE, main←in_data.
  - ONE: acc & con → ONE, main←in_data.
  - ONE: acc & !con → FULL, skid←in_data.
  - ONE: con & !acc → EMPTY, main←0.
  - ONE: neither → hold.
  - FULL: in_ready=0, so acc is impossible.
  - FULL: con → ONE, main←skid, skid←0.
  - FULL: !con → hold.
- Flush (flush=1) has the highest priority:
  - Next state is EMPTY; main←0, skid←0.
  - A beat accepted in the same cycle is dropped.
  - A beat consumed in the same cycle counts as delivered downstream.
- Data ordering: strictly FIFO. The skid beat is always younger than the main beat.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W−1. They do not wrap.
  - Counters are not cleared by flush.
  - A cycle with both stall and flush increments both counters.
- X-safety: payload registers load only on the conditions above; in_data is never sampled when acc=0.

## Timing
- Reset (asynchronous assert, synchronous release), all outputs:
  - state=EMPTY, out_valid=0, out_data=0.
  - in_ready=1.
  - stall_cnt=0, flush_cnt=0.
- Latency:
  - A beat accepted at edge N appears on out_* after edge N, i.e. in cycle N+1.
  - Latency is 1 cycle; throughput is 1 beat per cycle with out_ready held high.
- Back-pressure:
  - out_ready falling costs at most one extra accepted beat, which is caught in skid.
  - in_ready deasserts in the cycle after the stage reaches FULL.
  - in_ready reasserts in the cycle after the first consume from FULL.
- Flush: out_valid=0 and out_data=0 in the cycle after the flush edge; in_ready=1 in that same cycle.
- Reset mid-transfer: any held beats are discarded immediately on assertion. There is no partial delivery.

## Test plan
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles → out_data=1,2,3,4 one cycle later; in_ready stays 1; stall_cnt=0.
- Skid fill: hold out_ready=0 and send 0xA then 0xB.
  - Required: in_ready=0 from the cycle after 0xB is accepted; out_data=0xA held; stall_cnt increments each cycle.
  - Then raise out_ready: outputs are 0xA, then 0xB; in_ready=1 one cycle after the first consume.
- Flush while FULL: with beats 0xA and 0xB held, assert flush for 1 cycle together with in_valid and 0xC.
  - Required next cycle: out_valid=0, out_data=0, in_ready=1; flush_cnt=1.
  - 0xC is never output.
- Simultaneous accept and consume in ONE: main=5, send 6 with out_ready=1 → next cycle out_data=6, state ONE.
- Counter saturation: CNT_W=4, hold a stall for 20 cycles → stall_cnt reaches 15 and stays at 15.
- Async reset mid-operation: assert reset between edges while in FULL → out_valid=0, out_data=0 and in_ready=1 immediately; counters=0; after release a new beat passes with 1-cycle latency.
